// File: rtl/car_park_ctrl.sv
// Car-park controller: independent entry/exit gate FSMs sharing one slot occupancy map,
// timestamped tickets and a duration-based fee. Define CARPARK_FEE_CAP_EN to clamp fees at MAX_FEE.
module car_park_ctrl #(
  parameter int CAPACITY   = 8,
  parameter int ID_W       = 3,
  parameter int BAR_CYCLES = 16,
  parameter int TICK_DIV   = 1000,
  parameter int TIME_W     = 16,
  parameter int RATE       = 2,
  parameter int COST_W     = 16,
  parameter int MAX_FEE    = 100
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sin,
  input  logic                            sout,
  input  logic [ID_W-1:0]                 exit_ticket,
  input  logic                            pay,
  output logic                            bin,
  output logic                            bout,
  output logic                            full,
  output logic [$clog2(CAPACITY+1)-1:0]   free_cnt,
  output logic [ID_W-1:0]                 ticket_id,
  output logic                            ticket_vld,
  output logic [COST_W-1:0]               cost,
  output logic                            cost_vld,
  output logic                            err
);

  localparam int FREE_W = $clog2(CAPACITY + 1);
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BAR_W  = (BAR_CYCLES > 1) ? $clog2(BAR_CYCLES) : 1;
  localparam int FEE_W  = TIME_W + 33;
  localparam logic [FEE_W-1:0] COST_MAX = (FEE_W'(1) << COST_W) - FEE_W'(1);

  if (ID_W != $clog2(CAPACITY) || CAPACITY < 2 || BAR_CYCLES < 1 || MAX_FEE < 0) begin : g_bad_params
    $error("car_park_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {E_IDLE, E_WAIT, E_OPEN} e_state_t;
  typedef enum logic [1:0] {X_IDLE, X_PRICE, X_PAY, X_OPEN} x_state_t;

  e_state_t             e_state_q, e_state_d;
  x_state_t             x_state_q, x_state_d;
  logic [BAR_W-1:0]     e_cnt_q, e_cnt_d, x_cnt_q, x_cnt_d;
  logic [PRE_W-1:0]     presc_q, presc_d;
  logic [TIME_W-1:0]    now_q, now_d;
  logic [CAPACITY-1:0]  occ_q, occ_d;
  logic [FREE_W-1:0]    free_q, free_d;
  logic [ID_W-1:0]      tid_q, tid_d, x_tkt_q, x_tkt_d;
  logic                 tvld_q, tvld_d, err_q, err_d;
  logic [COST_W-1:0]    cost_q, cost_d;
  logic [TIME_W-1:0]    ts_q [CAPACITY];

  logic [ID_W-1:0]      alloc_idx;
  logic                 any_free, alloc, release_slot, slot_valid;
  logic [TIME_W-1:0]    dur;
  logic [TIME_W:0]      units;
  logic [FEE_W-1:0]     fee_wide;
  logic [COST_W-1:0]    fee;

  // Fee for the latched ticket; only consumed in X_PRICE, when the slot is known occupied.
  always_comb begin
    dur      = now_q - ts_q[x_tkt_q];
    units    = {1'b0, dur} + (TIME_W+1)'(1);
    fee_wide = FEE_W'(units) * FEE_W'(RATE);
`ifdef CARPARK_FEE_CAP_EN
    if (fee_wide > FEE_W'(MAX_FEE)) fee_wide = FEE_W'(MAX_FEE);
`endif
    fee = (fee_wide > COST_MAX) ? {COST_W{1'b1}} : fee_wide[COST_W-1:0];
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    presc_d = presc_q + 1'b1;
    now_d   = now_q;
    if (presc_q == PRE_W'(TICK_DIV - 1)) begin
      presc_d = '0;
      now_d   = now_q + 1'b1;
    end

    alloc_idx = '0;
    any_free  = 1'b0;
    for (int i = CAPACITY - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        alloc_idx = ID_W'(i);
        any_free  = 1'b1;
      end
    end

    e_state_d = e_state_q;
    e_cnt_d   = e_cnt_q;
    alloc     = 1'b0;
    unique case (e_state_q)
      E_IDLE:  if (sin) begin
                 if (any_free) alloc = 1'b1;
                 else          e_state_d = E_WAIT;
               end
      E_WAIT:  if (!sin)         e_state_d = E_IDLE;
               else if (any_free) alloc = 1'b1;
      E_OPEN:  if (e_cnt_q == BAR_W'(BAR_CYCLES - 1)) e_state_d = E_IDLE;
               else                                   e_cnt_d   = e_cnt_q + 1'b1;
      default: e_state_d = E_IDLE;
    endcase
    if (alloc) begin
      e_state_d = E_OPEN;
      e_cnt_d   = '0;
    end
    tvld_d = alloc;
    tid_d  = alloc ? alloc_idx : tid_q;

    slot_valid   = (int'(exit_ticket) < CAPACITY) ? occ_q[exit_ticket] : 1'b0;
    x_state_d    = x_state_q;
    x_cnt_d      = x_cnt_q;
    x_tkt_d      = x_tkt_q;
    cost_d       = cost_q;
    err_d        = 1'b0;
    release_slot = 1'b0;
    unique case (x_state_q)
      X_IDLE:  if (sout) begin
                 x_tkt_d = exit_ticket;
                 if (slot_valid) x_state_d = X_PRICE;
                 else            err_d     = 1'b1;
               end
      X_PRICE: begin
                 cost_d    = fee;
                 x_state_d = X_PAY;
               end
      X_PAY:   if (pay) begin
                 release_slot = 1'b1;
                 x_state_d    = X_OPEN;
                 x_cnt_d      = '0;
               end
      X_OPEN:  if (x_cnt_q == BAR_W'(BAR_CYCLES - 1)) x_state_d = X_IDLE;
               else                                   x_cnt_d   = x_cnt_q + 1'b1;
      default: x_state_d = X_IDLE;
    endcase

    // Allocation looks only at occ_q, so a slot freed this cycle is never reissued this cycle.
    occ_d = occ_q;
    if (alloc)        occ_d[alloc_idx] = 1'b1;
    if (release_slot) occ_d[x_tkt_q]   = 1'b0;
    free_d = free_q;
    if (alloc && !release_slot)      free_d = free_q - 1'b1;
    else if (release_slot && !alloc) free_d = free_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_state_q <= E_IDLE;
      x_state_q <= X_IDLE;
      e_cnt_q   <= '0;
      x_cnt_q   <= '0;
      presc_q   <= '0;
      now_q     <= '0;
      occ_q     <= '0;
      free_q    <= FREE_W'(CAPACITY);
      tid_q     <= '0;
      tvld_q    <= 1'b0;
      x_tkt_q   <= '0;
      cost_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      e_state_q <= e_state_d;
      x_state_q <= x_state_d;
      e_cnt_q   <= e_cnt_d;
      x_cnt_q   <= x_cnt_d;
      presc_q   <= presc_d;
      now_q     <= now_d;
      occ_q     <= occ_d;
      free_q    <= free_d;
      tid_q     <= tid_d;
      tvld_q    <= tvld_d;
      x_tkt_q   <= x_tkt_d;
      cost_q    <= cost_d;
      err_q     <= err_d;
    end
  end

  // NOTE: timestamps have no reset; a slot's occupancy bit qualifies every read of its entry.
  always_ff @(posedge clk) begin
    if (alloc) ts_q[alloc_idx] <= now_q;
  end

  assign bin        = (e_state_q == E_OPEN);
  assign bout       = (x_state_q == X_OPEN);
  assign cost_vld   = (x_state_q == X_PAY);
  assign full       = (free_q == '0);
  assign free_cnt   = free_q;
  assign ticket_id  = tid_q;
  assign ticket_vld = tvld_q;
  assign cost       = cost_q;
  assign err        = err_q;

endmodule

// File: tb/tb_car_park_ctrl.sv
// Self-checking bench for car_park_ctrl: directed scenarios plus random entries/exits against a
// slot/timestamp reference model. Honours CARPARK_FEE_CAP_EN when computing expected fees.
module tb_car_park_ctrl;

  localparam int CAPACITY   = 8;
  localparam int ID_W       = 3;
  localparam int BAR_CYCLES = 16;
  localparam int TICK_DIV   = 8;
  localparam int TIME_W     = 8;
  localparam int RATE       = 2;
  localparam int COST_W     = 9;
  localparam int MAX_FEE    = 100;
  localparam int TMOD       = 1 << TIME_W;
  localparam int COST_SAT   = (1 << COST_W) - 1;

  logic clk = 1'b0, rst = 1'b0, sin = 1'b0, sout = 1'b0, pay = 1'b0;
  logic [ID_W-1:0] exit_ticket = '0;
  logic bin, bout, full, ticket_vld, cost_vld, err;
  logic [$clog2(CAPACITY+1)-1:0] free_cnt;
  logic [ID_W-1:0] ticket_id;
  logic [COST_W-1:0] cost;

  int total = 0, bad = 0, cyc = 0;
  bit occ_m [CAPACITY];
  int ts_m  [CAPACITY];

  car_park_ctrl #(
    .CAPACITY(CAPACITY), .ID_W(ID_W), .BAR_CYCLES(BAR_CYCLES), .TICK_DIV(TICK_DIV),
    .TIME_W(TIME_W), .RATE(RATE), .COST_W(COST_W), .MAX_FEE(MAX_FEE)
  ) dut (
    .clk(clk), .rst(rst), .sin(sin), .sout(sout), .exit_ticket(exit_ticket), .pay(pay),
    .bin(bin), .bout(bout), .full(full), .free_cnt(free_cnt), .ticket_id(ticket_id),
    .ticket_vld(ticket_vld), .cost(cost), .cost_vld(cost_vld), .err(err)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release: the time unit at any edge follows from this alone.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int now_at_last_edge();
    return ((cyc - 1) / TICK_DIV) % TMOD;
  endfunction

  function automatic int free_m();
    int n = 0;
    for (int i = 0; i < CAPACITY; i++) if (!occ_m[i]) n++;
    return n;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < CAPACITY; i++) if (!occ_m[i]) return i;
    return -1;
  endfunction

  function automatic int fee_of(input int dur);
    int f = (dur + 1) * RATE;
`ifdef CARPARK_FEE_CAP_EN
    if (f > MAX_FEE) f = MAX_FEE;
`endif
    if (f > COST_SAT) f = COST_SAT;
    return f;
  endfunction

  task automatic do_reset();
    sin = 1'b0; sout = 1'b0; pay = 1'b0;
    rst = 1'b0;
    #7;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < CAPACITY; i++) occ_m[i] = 1'b0;
  endtask

  // Advance until the edge (offset+1) from now samples time unit 'target'.
  task automatic wait_now(input int target, input int offset, input string tag);
    int guard = 0;
    while ((((cyc + offset) / TICK_DIV) % TMOD) != target && guard < 5000) begin
      tick();
      guard++;
    end
    check({tag, ".in_time"}, 32'(guard < 5000), 1);
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while ((bin || bout) && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, ".bars_closed"}, {30'd0, bin, bout}, 0);
  endtask

  task automatic enter_car(input string tag);
    int id = lowest_free();
    int n  = 1;
    sin = 1'b1;
    tick();
    sin = 1'b0;
    check({tag, ".vld"}, 32'(ticket_vld), 1);
    check({tag, ".id"},  32'(ticket_id), id);
    check({tag, ".bin"}, 32'(bin), 1);
    occ_m[id] = 1'b1;
    ts_m[id]  = now_at_last_edge();
    check({tag, ".free"}, 32'(free_cnt), free_m());
    check({tag, ".full"}, 32'(full), 32'(free_m() == 0));
    tick();
    check({tag, ".vld_pulse"}, 32'(ticket_vld), 0);
    while (bin === 1'b1 && n < 64) begin
      n++;
      tick();
    end
    check({tag, ".bin_len"}, n, BAR_CYCLES);
  endtask

  task automatic exit_car(input int t, input string tag, output int fee_seen);
    bit valid = occ_m[t];
    int n = 1;
    int exp_fee;
    fee_seen = -1;
    exit_ticket = ID_W'(t);
    sout = 1'b1;
    tick();
    sout = 1'b0;
    if (!valid) begin
      check({tag, ".err"}, 32'(err), 1);
      tick();
      check({tag, ".err_pulse"}, 32'(err), 0);
      check({tag, ".no_cost_vld"}, 32'(cost_vld), 0);
      check({tag, ".no_bout"}, 32'(bout), 0);
      return;
    end
    check({tag, ".no_err"}, 32'(err), 0);
    tick();
    check({tag, ".cost_vld"}, 32'(cost_vld), 1);
    exp_fee = fee_of((now_at_last_edge() - ts_m[t] + TMOD) % TMOD);
    check({tag, ".cost"}, 32'(cost), exp_fee);
    fee_seen = int'(cost);
    repeat ($urandom_range(0, 3)) tick();
    check({tag, ".await_pay"}, 32'(cost_vld), 1);
    pay = 1'b1;
    tick();
    pay = 1'b0;
    occ_m[t] = 1'b0;
    check({tag, ".bout"}, 32'(bout), 1);
    check({tag, ".cost_vld_drop"}, 32'(cost_vld), 0);
    check({tag, ".free"}, 32'(free_cnt), free_m());
    tick();
    while (bout === 1'b1 && n < 64) begin
      n++;
      tick();
    end
    check({tag, ".bout_len"}, n, BAR_CYCLES);
    check({tag, ".cost_held"}, 32'(cost), exp_fee);
  endtask

  initial begin
    int f;
`ifdef CARPARK_FEE_CAP_EN
    int fee400 = 100, fee_sat = 100;
`else
    int fee400 = 400, fee_sat = COST_SAT;
`endif

    // Reset values while reset is held.
    #12;
    check("rst.bin",   32'(bin), 0);
    check("rst.bout",  32'(bout), 0);
    check("rst.full",  32'(full), 0);
    check("rst.free",  32'(free_cnt), CAPACITY);
    check("rst.tid",   32'(ticket_id), 0);
    check("rst.tvld",  32'(ticket_vld), 0);
    check("rst.cost",  32'(cost), 0);
    check("rst.cvld",  32'(cost_vld), 0);
    check("rst.err",   32'(err), 0);
    @(negedge clk);
    rst = 1'b1;

    // First entry, then fill the park.
    enter_car("first");
    for (int i = 1; i < CAPACITY; i++) enter_car("fill");
    check("fill.full", 32'(full), 1);

    // Ninth car waits; releasing ticket 3 lets it in on the following edge.
    sin = 1'b1;
    tick();
    check("wait.no_vld", 32'(ticket_vld), 0);
    repeat (3) tick();
    check("wait.no_bin", 32'(bin), 0);
    check("wait.full",   32'(full), 1);
    exit_ticket = 3'd3;
    sout = 1'b1;
    tick();
    sout = 1'b0;
    tick();
    check("rel3.cost_vld", 32'(cost_vld), 1);
    pay = 1'b1;
    tick();
    pay = 1'b0;
    occ_m[3] = 1'b0;
    check("rel3.bout", 32'(bout), 1);
    check("rel3.free", 32'(free_cnt), 1);
    check("rel3.not_full", 32'(full), 0);
    check("rel3.no_vld", 32'(ticket_vld), 0);
    tick();
    check("reissue.vld",  32'(ticket_vld), 1);
    check("reissue.id",   32'(ticket_id), 3);
    check("reissue.free", 32'(free_cnt), 0);
    check("reissue.full", 32'(full), 1);
    occ_m[3] = 1'b1;
    sin = 1'b0;
    wait_idle("reissue");

    // Entry at unit 5, exit priced at unit 9; an unoccupied ticket is rejected.
    do_reset();
    wait_now(5, 0, "w5");
    enter_car("e5");
    exit_car(6, "bad6", f);
    wait_now(9, 1, "w9");
    exit_car(0, "x9", f);
    check("fee.5_to_9", f, 10);

    // Long stay, wrap-around and saturation in one time epoch.
    do_reset();
    wait_now(10, 0, "w10");
    enter_car("e10");
    wait_now(20, 0, "w20");
    enter_car("e20");
    wait_now(209, 1, "w209");
    exit_car(0, "x209", f);
    check("fee.long_stay", f, fee400);
    wait_now(254, 0, "w254");
    enter_car("e254");
    wait_now(3, 1, "w3");
    exit_car(0, "x3", f);
    check("fee.wrap", f, 12);
    wait_now(19, 1, "w19");
    exit_car(1, "x19", f);
    check("fee.saturate", f, fee_sat);

    // Same-edge allocation and release with one slot free.
    do_reset();
    for (int i = 0; i < CAPACITY - 1; i++) enter_car("pre");
    exit_ticket = 3'd2;
    sout = 1'b1;
    tick();
    sout = 1'b0;
    tick();
    check("same.cost_vld", 32'(cost_vld), 1);
    sin = 1'b1;
    pay = 1'b1;
    tick();
    sin = 1'b0;
    pay = 1'b0;
    check("same.vld",  32'(ticket_vld), 1);
    check("same.id",   32'(ticket_id), 7);
    check("same.new_ne_released", 32'(ticket_id != 3'd2), 1);
    check("same.free", 32'(free_cnt), 1);
    check("same.bout", 32'(bout), 1);
    check("same.bin",  32'(bin), 1);
    wait_idle("same");

    // Reset during the entry bar.
    sin = 1'b1;
    tick();
    sin = 1'b0;
    check("midrst.bin_before", 32'(bin), 1);
    #2 rst = 1'b0;
    #1;
    check("midrst.bin",  32'(bin), 0);
    check("midrst.free", 32'(free_cnt), CAPACITY);
    check("midrst.full", 32'(full), 0);
    check("midrst.bout", 32'(bout), 0);
    check("midrst.cvld", 32'(cost_vld), 0);
    check("midrst.tvld", 32'(ticket_vld), 0);
    check("midrst.cost", 32'(cost), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < CAPACITY; i++) occ_m[i] = 1'b0;

    // Random traffic against the model; pay pulses while idle must be ignored.
    for (int k = 0; k < 80; k++) begin
      int r = $urandom_range(0, 9);
      if (r < 4 && free_m() > 0) begin
        enter_car("rnd_in");
      end else if (r < 8) begin
        exit_car($urandom_range(0, CAPACITY - 1), "rnd_out", f);
      end else begin
        pay = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 30)) tick();
        pay = 1'b0;
        check("rnd_idle.bout", 32'(bout), 0);
        check("rnd_idle.cvld", 32'(cost_vld), 0);
      end
      check("rnd.free", 32'(free_cnt), free_m());
      check("rnd.full", 32'(full), 32'(free_m() == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
